ctrl_step_sequencer: RTL and testbench

Synthesizable control-step generator for the CPU datapath. It produces the one-hot T-step vector that the control unit decodes into register, bus, ALU and memory strobes: fetch steps, a variable-length execute phase, memory-wait stalls, and a clean halt. It generalises the fixed T0..T6 stepping used in bring-up benches to a parametrised step count and fetch length, with early instruction termination, stall handling, and optional performance counters.

---
 rtl/ctrl_step_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ctrl_step_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_step_sequencer.sv
// ctrl_step_sequencer: one-hot T-step generator for the CPU control unit.
// Produces fetch/execute steps with memory-wait stalls, early instruction
// termination and a reset-only halt state.
//
// Optional feature macro: SEQ_PERF_CNT_EN
//   When defined, adds the cycle_count / instr_count ports and the counter
//   logic. Sequencing is identical with or without it.
//
// Ports:
//   clk          rising-edge system clock
//   reset        synchronous, active-low reset
//   run          level enable for instruction stepping
//   mem_wait     memory not ready; holds the current step
//   end_instr    marks the current execute step as the final one
//   halt_req     halt instruction flag, sampled at the final step
//   step         one-hot current T-step (zero when not running)
//   step_idx     binary index of the current step
//   fetch        high during the leading fetch steps while running
//   con_reset    high during T0 while running
//   running      high in RUN
//   halted       high in HALT
//   cycle_count  RUN cycles including stalls   (SEQ_PERF_CNT_EN only)
//   instr_count  completed instructions        (SEQ_PERF_CNT_EN only)

module ctrl_step_sequencer #(
    parameter int NUM_STEPS   = 8,
    parameter int FETCH_STEPS = 3,
    parameter int CNT_W       = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic                         mem_wait,
    input  logic                         end_instr,
    input  logic                         halt_req,
    output logic [NUM_STEPS-1:0]         step,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         fetch,
    output logic                         con_reset,
    output logic                         running,
    output logic                         halted
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [CNT_W-1:0]             instr_count
`endif
);

    localparam int IDX_W = $clog2(NUM_STEPS);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_STEPS - 1);
    localparam logic [IDX_W-1:0] FIRST_EXEC = IDX_W'(FETCH_STEPS);

    localparam logic [NUM_STEPS-1:0] STEP_T0 = {{(NUM_STEPS-1){1'b0}}, 1'b1};

    if (NUM_STEPS < 4 || NUM_STEPS > 16) begin : g_bad_num_steps
        $error("ctrl_step_sequencer: NUM_STEPS must be 4..16");
    end

    if (FETCH_STEPS < 1 || FETCH_STEPS > NUM_STEPS - 1) begin : g_bad_fetch
        $error("ctrl_step_sequencer: FETCH_STEPS must be 1..NUM_STEPS-1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic               final_step;

    // end_instr only counts once the fetch steps are over; the last
    // step is always final regardless of the decoder.
    always_comb begin
        final_step = (idx == LAST_IDX) ||
                     (end_instr && (idx >= FIRST_EXEC));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        unique case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = S_RUN;
                    idx_nxt   = '0;
                end
            end
            S_RUN: begin
                // A stall outranks completion, even in the final step.
                if (mem_wait) begin
                    idx_nxt = idx;
                end else if (final_step) begin
                    idx_nxt = '0;
                    if (halt_req) begin
                        state_nxt = S_HALT;
                    end else if (!run) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Outputs decode only the registered state and index.
    always_comb begin
        running   = (state == S_RUN);
        halted    = (state == S_HALT);
        step_idx  = idx;
        step      = '0;
        fetch     = 1'b0;
        con_reset = 1'b0;
        if (running) begin
            step      = STEP_T0 << idx;
            fetch     = (idx < FIRST_EXEC);
            con_reset = (idx == '0);
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic complete;

    always_comb begin
        complete = (state == S_RUN) && !mem_wait && final_step;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (state == S_RUN) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (complete) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// tb_ctrl_step_sequencer: table vectors, directed corner sequences and
// randomized stimulus against a behavioural model of the step sequencer.

module tb_ctrl_step_sequencer;

    localparam int NS = 8;
    localparam int FS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       mem_wait;
    logic       end_instr;
    logic       halt_req;
    logic [7:0] step;
    logic [2:0] step_idx;
    logic       fetch;
    logic       con_reset;
    logic       running;
    logic       halted;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
`endif

    int passed = 0;
    int total  = 0;

    ctrl_step_sequencer #(
        .NUM_STEPS  (NS),
        .FETCH_STEPS(FS),
        .CNT_W      (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .mem_wait   (mem_wait),
        .end_instr  (end_instr),
        .halt_req   (halt_req),
        .step       (step),
        .step_idx   (step_idx),
        .fetch      (fetch),
        .con_reset  (con_reset),
        .running    (running),
        .halted     (halted)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_count(cycle_count),
        .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       run;
        logic       mw;
        logic       ei;
        logic       hr;
        logic [7:0] st;
        logic [2:0] ix;
        logic [3:0] fl;
    } vec_t;

    vec_t tbl[18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [14:0] outv();
        return {step, step_idx, fetch, con_reset, running, halted};
    endfunction

    // mode: 0 idle, 1 run, 2 halt
    function automatic logic [14:0] expv(input int mode, input int pos);
        logic [7:0] s;
        logic [2:0] ix;
        logic       f;
        logic       c;
        s  = 8'h00;
        ix = 3'(pos);
        f  = 1'b0;
        c  = 1'b0;
        if (mode == 1) begin
            s = 8'(1 << pos);
            f = (pos < FS);
            c = (pos == 0);
        end
        return {s, ix, f, c, (mode == 1), (mode == 2)};
    endfunction

    task automatic set_in(input logic r, input logic rn, input logic mw,
                          input logic ei, input logic hr);
        reset     = r;
        run       = rn;
        mem_wait  = mw;
        end_instr = ei;
        halt_req  = hr;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Behavioural model state
    int          m_mode;
    int          m_pos;
    logic [31:0] m_cyc;
    logic [31:0] m_ins;

    task automatic model_step();
        bit last;
        if (!reset) begin
            m_mode = 0;
            m_pos  = 0;
            m_cyc  = 0;
            m_ins  = 0;
        end else if (m_mode == 0) begin
            if (run) begin
                m_mode = 1;
                m_pos  = 0;
            end
        end else if (m_mode == 1) begin
            m_cyc = m_cyc + 1;
            last  = (m_pos == NS - 1) || (end_instr && m_pos >= FS);
            if (mem_wait) begin
                m_pos = m_pos;
            end else if (last) begin
                m_ins = m_ins + 1;
                m_pos = 0;
                if (halt_req) m_mode = 2;
                else if (!run) m_mode = 0;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    endtask

    initial begin
        // rst run mw ei hr | step idx {fetch,con,running,halted}
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 4'b0000};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 4'b0000};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 3'd0, 4'b1110};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 3'd1, 4'b1010};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04, 3'd2, 4'b1010};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 3'd3, 4'b0010};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 3'd4, 4'b0010};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 3'd5, 4'b0010};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 3'd6, 4'b0010};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 3'd7, 4'b0010};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 3'd0, 4'b1110};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 3'd1, 4'b1010};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h04, 3'd2, 4'b1010};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 3'd3, 4'b0010};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 3'd4, 4'b0010};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 3'd0, 4'b1110};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 3'd0, 4'b1110};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 3'd1, 4'b1010};

        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].rst, tbl[i].run, tbl[i].mw, tbl[i].ei, tbl[i].hr);
            tick();
            chk($sformatf("vec%0d", i), outv(),
                {tbl[i].st, tbl[i].ix, tbl[i].fl});
        end

        // Early end in step 4
        do_reset();
        chk("reset_idle", outv(), expv(0, 0));
`ifdef SEQ_PERF_CNT_EN
        chk("reset_cyc", cycle_count, 0);
        chk("reset_ins", instr_count, 0);
`endif
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) tick();
        chk("early_t4", outv(), expv(1, 4));
        end_instr = 1'b1;
        tick();
        end_instr = 1'b0;
        chk("early_next_t0", outv(), expv(1, 0));
`ifdef SEQ_PERF_CNT_EN
        chk("early_cyc", cycle_count, 5);
        chk("early_ins", instr_count, 1);
`endif

        // Stall three cycles in step 1
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        mem_wait = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall_hold%0d", k), outv(), expv(1, 1));
        end
        mem_wait = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("stall_t7", outv(), expv(1, 7));
        tick();
        chk("stall_done_t0", outv(), expv(1, 0));
`ifdef SEQ_PERF_CNT_EN
        chk("stall_cyc", cycle_count, 11);
        chk("stall_ins", instr_count, 1);
`endif

        // Stall in the final step delays completion
        mem_wait = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        mem_wait = 1'b1;
        tick();
        chk("final_stall", outv(), expv(1, 7));
        mem_wait = 1'b0;
        tick();
        chk("final_release", outv(), expv(1, 0));

        // Halt with end_instr in step 3
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        halt_req = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("halt_ignored_nonfinal", outv(), expv(1, 3));
        end_instr = 1'b1;
        tick();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("halt_entered", outv(), expv(2, 0));
        for (int k = 0; k < 4; k++) begin
            run = k[0];
            tick();
        end
        chk("halt_sticky", outv(), expv(2, 0));
        do_reset();
        chk("halt_reset_exit", outv(), expv(0, 0));

        // Run dropped in step 2 completes the instruction
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        run = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("drop_t7", outv(), expv(1, 7));
        tick();
        chk("drop_idle", outv(), expv(0, 0));
`ifdef SEQ_PERF_CNT_EN
        chk("drop_cyc", cycle_count, 8);
        chk("drop_ins", instr_count, 1);
`endif

        // Reset in step 5 during a stall
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) tick();
        mem_wait = 1'b1;
        tick();
        chk("midrst_t5", outv(), expv(1, 5));
        reset = 1'b0;
        tick();
        chk("midrst_idle", outv(), expv(0, 0));
`ifdef SEQ_PERF_CNT_EN
        chk("midrst_cyc", cycle_count, 0);
        chk("midrst_ins", instr_count, 0);
`endif

        // Randomized run against the model
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_step();
        tick();
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 63) != 0);
            run       = ($urandom_range(0, 7) != 0);
            mem_wait  = ($urandom_range(0, 3) == 0);
            end_instr = ($urandom_range(0, 3) == 0);
            halt_req  = ($urandom_range(0, 31) == 0);
            model_step();
            tick();
            chk($sformatf("rnd%0d", i), outv(), expv(m_mode, m_pos));
`ifdef SEQ_PERF_CNT_EN
            chk($sformatf("rnd_cnt%0d", i), {cycle_count, instr_count},
                {m_cyc, m_ins});
`endif
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
